activation: RTL and testbench

//  Parametrised neuron activation unit with forward and backward paths.
//  - Forward: takes a signed pre-activation argument and returns a saturated

---
 rtl/activation_if.sv | 29 ++
 rtl/activation.sv | 177 +++++++++++++++++
 tb/tb_activation.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/activation_if.sv
// rtl/activation_if.sv - argument/result/error/feedback handshakes around the activation unit
interface activation_if #(
  parameter int ARG_WIDTH = 16,
  parameter int RES_WIDTH = 8,
  parameter int ERR_WIDTH = 16
);
  logic                 arg_stb;
  logic                 arg_rdy;
  logic [ARG_WIDTH-1:0] arg_dat;
  logic                 res_stb;
  logic                 res_rdy;
  logic [RES_WIDTH-1:0] res_dat;
  logic                 err_stb;
  logic                 err_rdy;
  logic [ERR_WIDTH-1:0] err_dat;
  logic                 fbk_stb;
  logic                 fbk_rdy;
  logic [ERR_WIDTH-1:0] fbk_dat;

  modport master (
    output arg_stb, arg_dat, res_rdy, err_stb, err_dat, fbk_rdy,
    input  arg_rdy, res_stb, res_dat, err_rdy, fbk_stb, fbk_dat
  );

  modport slave (
    input  arg_stb, arg_dat, res_rdy, err_stb, err_dat, fbk_rdy,
    output arg_rdy, res_stb, res_dat, err_rdy, fbk_stb, fbk_dat
  );
endinterface

// File: rtl/activation.sv
// rtl/activation.sv - neuron activation (hard sigmoid / ReLU) with forward path,
// saved-result FIFO and two-stage backward derivative path
module activation #(
  parameter int ARG_WIDTH = 16,
  parameter int RES_WIDTH = 8,
  parameter int ERR_WIDTH = 16,
  parameter int DEPTH     = 4,
  parameter int MODE      = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  activation_if.slave                bus,
  output logic [$clog2(DEPTH+1)-1:0] cnt
);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PROD_W = ERR_WIDTH + 2 * RES_WIDTH + 2;
  localparam int SAT    = 2 ** (RES_WIDTH + 3);

  localparam logic signed [ARG_WIDTH-1:0] ARG_HI  = ARG_WIDTH'(SAT - 1);
  localparam logic signed [ARG_WIDTH-1:0] ARG_LO  = ARG_WIDTH'(-SAT);
  localparam logic signed [ARG_WIDTH-1:0] RES_MAX = ARG_WIDTH'((1 << RES_WIDTH) - 1);
  localparam logic signed [PROD_W-1:0]    ONE_P   = PROD_W'(1);
  localparam logic signed [PROD_W-1:0]    RND     = ONE_P <<< (2 * RES_WIDTH - 1);
  localparam logic signed [PROD_W-1:0]    ERR_MAX = (ONE_P <<< (ERR_WIDTH - 1)) - ONE_P;
  localparam logic signed [PROD_W-1:0]    ERR_MIN = -(ONE_P <<< (ERR_WIDTH - 1));

  logic                        res_stb_q, res_stb_d;
  logic [RES_WIDTH-1:0]        res_dat_q, res_dat_d;
  logic                        busy_q, busy_d;
  logic signed [PROD_W-1:0]    prod_q, prod_d;
  logic                        fbk_stb_q, fbk_stb_d;
  logic [ERR_WIDTH-1:0]        fbk_dat_q, fbk_dat_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
  logic [RES_WIDTH-1:0]        mem_q [DEPTH];
  logic [RES_WIDTH-1:0]        mem_d [DEPTH];

  logic                        arg_rdy, err_rdy, arg_fire, err_fire, push;
  logic [RES_WIDTH-1:0]        res_calc, head;
  logic signed [ARG_WIDTH-1:0] arg_s, clamped, biased;
  logic [RES_WIDTH:0]          comp;
  logic [2*RES_WIDTH:0]        deriv;
  logic signed [PROD_W-1:0]    rounded;

  // Ready terms never look at the same side's strobe.
  always_comb begin : handshake
    arg_rdy  = (!res_stb_q || bus.res_rdy) && !(en && (cnt_q == CNT_W'(DEPTH)));
    err_rdy  = en && (cnt_q != '0) && !busy_q && !fbk_stb_q;
    arg_fire = bus.arg_stb && arg_rdy;
    err_fire = bus.err_stb && err_rdy;
    push     = arg_fire && en;
  end

  always_comb begin : forward_math
    arg_s    = $signed(bus.arg_dat);
    clamped  = arg_s;
    biased   = '0;
    res_calc = '0;
    if (MODE == 0) begin
      if (arg_s > ARG_HI) begin
        clamped = ARG_HI;
      end else if (arg_s < ARG_LO) begin
        clamped = ARG_LO;
      end
      biased   = clamped + ARG_WIDTH'(SAT);
      res_calc = RES_WIDTH'(biased >>> 4);
    end else if (arg_s > 0) begin
      biased = arg_s >>> 4;
      if (biased > RES_MAX) begin
        res_calc = '1;
      end else begin
        res_calc = RES_WIDTH'(biased);
      end
    end
  end

  always_comb begin : forward_regs
    res_stb_d = res_stb_q;
    res_dat_d = res_dat_q;
    if (arg_fire) begin
      res_stb_d = 1'b1;
      res_dat_d = res_calc;
    end else if (bus.res_rdy) begin
      res_stb_d = 1'b0;
    end
  end

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  always_comb begin : fifo
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = res_calc;
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (err_fire) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    if (push && !err_fire) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (err_fire && !push) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Stage 1 registers the full-precision product; stage 2 rounds and saturates.
  always_comb begin : backward
    head   = mem_q[rd_ptr_q];
    comp   = {1'b1, {RES_WIDTH{1'b0}}} - {1'b0, head};
    deriv  = {{(RES_WIDTH + 1){1'b0}}, head} * {{RES_WIDTH{1'b0}}, comp};
    busy_d = err_fire;
    prod_d = prod_q;
    if (err_fire) begin
      if (MODE == 0) begin
        prod_d = PROD_W'($signed(bus.err_dat)) * PROD_W'($signed({1'b0, deriv}));
      end else begin
        prod_d = (head != '0) ? PROD_W'($signed(bus.err_dat)) : '0;
      end
    end
    rounded   = (MODE == 0) ? ((prod_q + RND) >>> (2 * RES_WIDTH)) : prod_q;
    fbk_stb_d = fbk_stb_q;
    fbk_dat_d = fbk_dat_q;
    if (busy_q) begin
      fbk_stb_d = 1'b1;
      if (rounded > ERR_MAX) begin
        fbk_dat_d = ERR_WIDTH'(ERR_MAX);
      end else if (rounded < ERR_MIN) begin
        fbk_dat_d = ERR_WIDTH'(ERR_MIN);
      end else begin
        fbk_dat_d = ERR_WIDTH'(rounded);
      end
    end else if (bus.fbk_rdy) begin
      fbk_stb_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_stb_q <= 1'b0;
      res_dat_q <= '0;
      busy_q    <= 1'b0;
      prod_q    <= '0;
      fbk_stb_q <= 1'b0;
      fbk_dat_q <= '0;
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      res_stb_q <= res_stb_d;
      res_dat_q <= res_dat_d;
      busy_q    <= busy_d;
      prod_q    <= prod_d;
      fbk_stb_q <= fbk_stb_d;
      fbk_dat_q <= fbk_dat_d;
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      mem_q     <= mem_d;
    end
  end

  assign bus.arg_rdy = arg_rdy;
  assign bus.err_rdy = err_rdy;
  assign bus.res_stb = res_stb_q;
  assign bus.res_dat = res_dat_q;
  assign bus.fbk_stb = fbk_stb_q;
  assign bus.fbk_dat = fbk_dat_q;
  assign cnt         = cnt_q;
endmodule

// File: tb/tb_activation.sv
// tb/tb_activation.sv - bench driving a hard-sigmoid and a ReLU instance with identical stimulus
module tb_activation;
  logic        clk = 1'b0;
  logic        rst, en;
  logic        arg_stb, res_rdy, err_stb, fbk_rdy;
  logic [15:0] arg_dat, err_dat;
  logic [2:0]  cnt_s, cnt_r;

  int checks = 0;
  int errors = 0;

  logic [7:0]  exp_res_s[$], exp_res_r[$], sav_s[$], sav_r[$];
  logic [15:0] exp_fbk_s[$], exp_fbk_r[$];

  typedef struct {
    logic [15:0] arg;
    logic [7:0]  res_s;
    logic [7:0]  res_r;
  } vec_t;
  vec_t vecs[12];

  activation_if #(.ARG_WIDTH(16), .RES_WIDTH(8), .ERR_WIDTH(16)) if_s();
  activation_if #(.ARG_WIDTH(16), .RES_WIDTH(8), .ERR_WIDTH(16)) if_r();

  activation #(.ARG_WIDTH(16), .RES_WIDTH(8), .ERR_WIDTH(16), .DEPTH(4), .MODE(0)) u_sig (
    .clk(clk), .rst(rst), .en(en), .bus(if_s), .cnt(cnt_s));
  activation #(.ARG_WIDTH(16), .RES_WIDTH(8), .ERR_WIDTH(16), .DEPTH(4), .MODE(1)) u_relu (
    .clk(clk), .rst(rst), .en(en), .bus(if_r), .cnt(cnt_r));

  assign if_s.arg_stb = arg_stb;  assign if_r.arg_stb = arg_stb;
  assign if_s.arg_dat = arg_dat;  assign if_r.arg_dat = arg_dat;
  assign if_s.res_rdy = res_rdy;  assign if_r.res_rdy = res_rdy;
  assign if_s.err_stb = err_stb;  assign if_r.err_stb = err_stb;
  assign if_s.err_dat = err_dat;  assign if_r.err_dat = err_dat;
  assign if_s.fbk_rdy = fbk_rdy;  assign if_r.fbk_rdy = fbk_rdy;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] fwd_sig(input logic [15:0] a);
    int v = int'($signed(a));
    if (v > 2047) v = 2047;
    if (v < -2048) v = -2048;
    return 8'((v + 2048) / 16);
  endfunction

  function automatic logic [7:0] fwd_relu(input logic [15:0] a);
    int v = int'($signed(a));
    if (v <= 0) return 8'h00;
    v = v / 16;
    if (v > 255) v = 255;
    return 8'(v);
  endfunction

  function automatic logic [15:0] bwd_sig(input logic [15:0] e, input logic [7:0] s);
    longint p = longint'($signed(e)) * longint'(s) * longint'(256 - int'(s)) + 64'sd32768;
    p = p >>> 16;
    if (p > 32767) p = 32767;
    if (p < -32768) p = -32768;
    return 16'(p);
  endfunction

  function automatic logic [15:0] bwd_relu(input logic [15:0] e, input logic [7:0] s);
    return (s != 8'h00) ? e : 16'h0000;
  endfunction

  // Entered just after a rising edge; returns just after the transfer edge.
  task automatic send_arg(input logic [15:0] a, input logic [7:0] es, input logic [7:0] er);
    int n = 0;
    arg_stb = 1'b1;
    arg_dat = a;
    @(negedge clk);
    while (!if_s.arg_rdy && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!if_s.arg_rdy) begin
      checks++; errors++;
      $display("FAIL arg_timeout: arg_rdy stayed 0 for arg %0h, required 1", a);
      @(posedge clk); #1;
      arg_stb = 1'b0;
      return;
    end
    exp_res_s.push_back(es);
    exp_res_r.push_back(er);
    if (en) begin
      sav_s.push_back(es);
      sav_r.push_back(er);
    end
    @(posedge clk); #1;
    arg_stb = 1'b0;
  endtask

  task automatic send_err(input logic [15:0] e, output logic [15:0] got_s, output logic [15:0] got_r);
    int n = 0;
    logic [7:0] ss, sr;
    got_s = '0;
    got_r = '0;
    err_stb = 1'b1;
    err_dat = e;
    @(negedge clk);
    while (!if_s.err_rdy && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!if_s.err_rdy || sav_s.size() == 0) begin
      checks++; errors++;
      $display("FAIL err_timeout: err_rdy=%0b saved=%0d, required err_rdy 1 with saved entries",
               if_s.err_rdy, sav_s.size());
      @(posedge clk); #1;
      err_stb = 1'b0;
      return;
    end
    ss = sav_s.pop_front();
    sr = sav_r.pop_front();
    exp_fbk_s.push_back(bwd_sig(e, ss));
    exp_fbk_r.push_back(bwd_relu(e, sr));
    @(posedge clk); #1;
    err_stb = 1'b0;
    @(negedge clk);
    check("fbk_lat1", if_s.fbk_stb, 1'b0);
    @(negedge clk);
    check("fbk_lat2", if_s.fbk_stb, 1'b1);
    got_s = if_s.fbk_dat;
    got_r = if_r.fbk_dat;
    @(posedge clk); #1;
  endtask

  // Scoreboard: compares each result/feedback on the edge it is accepted.
  always @(negedge clk) begin
    if (!rst) begin
      if (if_s.res_stb && if_s.res_rdy) begin
        if (exp_res_s.size() == 0) begin
          checks++; errors++;
          $display("FAIL res_sig_unexpected: got %0h with nothing expected", if_s.res_dat);
        end else check("res_sig", if_s.res_dat, exp_res_s.pop_front());
      end
      if (if_r.res_stb && if_r.res_rdy) begin
        if (exp_res_r.size() == 0) begin
          checks++; errors++;
          $display("FAIL res_relu_unexpected: got %0h with nothing expected", if_r.res_dat);
        end else check("res_relu", if_r.res_dat, exp_res_r.pop_front());
      end
      if (if_s.fbk_stb && if_s.fbk_rdy) begin
        if (exp_fbk_s.size() == 0) begin
          checks++; errors++;
          $display("FAIL fbk_sig_unexpected: got %0h with nothing expected", if_s.fbk_dat);
        end else check("fbk_sig", if_s.fbk_dat, exp_fbk_s.pop_front());
      end
      if (if_r.fbk_stb && if_r.fbk_rdy) begin
        if (exp_fbk_r.size() == 0) begin
          checks++; errors++;
          $display("FAIL fbk_relu_unexpected: got %0h with nothing expected", if_r.fbk_dat);
        end else check("fbk_relu", if_r.fbk_dat, exp_fbk_r.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench still running at %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [15:0] gs, gr, a;
    int n;
    vecs[0]  = '{16'h0000, 8'h80, 8'h00};
    vecs[1]  = '{16'h07ff, 8'hff, 8'h7f};
    vecs[2]  = '{16'h7fff, 8'hff, 8'hff};
    vecs[3]  = '{16'hf800, 8'h00, 8'h00};
    vecs[4]  = '{16'h8000, 8'h00, 8'h00};
    vecs[5]  = '{16'h0100, 8'h90, 8'h10};
    vecs[6]  = '{16'hff00, 8'h70, 8'h00};
    vecs[7]  = '{16'h0010, 8'h81, 8'h01};
    vecs[8]  = '{16'h000f, 8'h80, 8'h00};
    vecs[9]  = '{16'hffff, 8'h7f, 8'h00};
    vecs[10] = '{16'h0ff0, 8'hff, 8'hff};
    vecs[11] = '{16'h1000, 8'hff, 8'hff};

    rst = 1'b1; en = 1'b0;
    arg_stb = 1'b0; arg_dat = '0; res_rdy = 1'b1;
    err_stb = 1'b0; err_dat = '0; fbk_rdy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_res_stb", if_s.res_stb, 1'b0);
    check("rst_fbk_stb", if_r.fbk_stb, 1'b0);
    check("rst_res_dat", if_s.res_dat, 8'h00);
    check("rst_fbk_dat", if_s.fbk_dat, 16'h0000);
    check("rst_cnt", cnt_s, 3'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Untrained forward vectors on both modes
    foreach (vecs[i]) send_arg(vecs[i].arg, vecs[i].res_s, vecs[i].res_r);
    @(negedge clk);
    check("untrained_cnt", cnt_s, 3'd0);
    @(posedge clk); #1;

    // Single training round trip
    en = 1'b1;
    send_arg(16'h0000, 8'h80, 8'h00);
    check("train_cnt1", cnt_s, 3'd1);
    send_err(16'd255, gs, gr);
    check("train_fbk", gs, 16'h0040);
    check("train_cnt0", cnt_s, 3'd0);

    // Fill FIFO, bypass while full with en=0, then fifth arg waits for a pop
    send_arg(16'hfc00, 8'h40, 8'h00);
    send_arg(16'h0600, 8'he0, 8'h60);
    send_arg(16'hf900, 8'h10, 8'h00);
    send_arg(16'h0000, 8'h80, 8'h00);
    check("full_cnt", cnt_s, 3'd4);
    en = 1'b0;
    @(negedge clk);
    check("en_low_err_rdy", if_s.err_rdy, 1'b0);
    @(posedge clk); #1;
    send_arg(16'h0010, 8'h81, 8'h01);
    check("full_bypass_cnt", cnt_r, 3'd4);
    en = 1'b1;
    fork
      send_arg(16'h0100, 8'h90, 8'h10);
      begin
        repeat (3) begin
          @(negedge clk);
          check("full_arg_rdy", if_s.arg_rdy, 1'b0);
        end
        @(posedge clk); #1;
        send_err(16'd255, gs, gr);
        check("order_fbk0", gs, 16'd48);
      end
    join
    send_err(16'd255, gs, gr);
    check("order_fbk1", gs, 16'd28);
    check("order_relu1", gr, 16'd255);
    send_err(16'd255, gs, gr);
    check("order_fbk2", gs, 16'd15);
    send_err(16'd255, gs, gr);
    check("order_fbk3", gs, 16'd64);
    send_err(16'd255, gs, gr);
    check("order_fbk4", gs, 16'd63);
    check("order_cnt", cnt_s, 3'd0);

    // Result backpressure
    en = 1'b0;
    res_rdy = 1'b0;
    send_arg(16'h0010, 8'h81, 8'h01);
    repeat (3) begin
      @(negedge clk);
      check("bp_res_stb", if_s.res_stb, 1'b1);
      check("bp_res_dat", if_s.res_dat, 8'h81);
      check("bp_arg_rdy", if_s.arg_rdy, 1'b0);
    end
    @(posedge clk); #1;
    res_rdy = 1'b1;

    // Feedback backpressure
    en = 1'b1;
    send_arg(16'h0600, 8'he0, 8'h60);
    send_arg(16'h0000, 8'h80, 8'h00);
    fbk_rdy = 1'b0;
    send_err(16'd255, gs, gr);
    repeat (3) begin
      @(negedge clk);
      check("bp_fbk_stb", if_s.fbk_stb, 1'b1);
      check("bp_fbk_dat", if_s.fbk_dat, 16'd28);
      check("bp_err_rdy", if_s.err_rdy, 1'b0);
    end
    @(posedge clk); #1;
    fbk_rdy = 1'b1;
    send_err(16'd255, gs, gr);
    check("bp_fbk_after", gs, 16'd64);

    // ReLU feedback gating
    send_arg(16'h0100, 8'h90, 8'h10);
    send_arg(16'hff00, 8'h70, 8'h00);
    send_err(16'hff9c, gs, gr);
    check("relu_fbk_neg", gr, 16'hff9c);
    send_err(16'd77, gs, gr);
    check("relu_fbk_zero", gr, 16'h0000);

    // Reset while a backward op is in flight
    send_arg(16'h0000, 8'h80, 8'h00);
    send_arg(16'h0100, 8'h90, 8'h10);
    send_arg(16'hff00, 8'h70, 8'h00);
    check("mid_cnt3", cnt_s, 3'd3);
    err_stb = 1'b1;
    err_dat = 16'd255;
    n = 0;
    @(negedge clk);
    while (!if_s.err_rdy && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("mid_err_rdy", if_s.err_rdy, 1'b1);
    @(posedge clk); #1;
    err_stb = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sav_s.delete();
    sav_r.delete();
    repeat (4) begin
      @(negedge clk);
      check("mid_fbk_stb", if_s.fbk_stb | if_r.fbk_stb, 1'b0);
      check("mid_cnt", cnt_s, 3'd0);
      check("mid_err_rdy0", if_s.err_rdy, 1'b0);
    end
    @(posedge clk); #1;

    // Randomised mix of trained and untrained traffic
    for (int i = 0; i < 24; i++) begin
      en = 1'($urandom);
      a  = 16'($urandom_range(0, 8191)) - 16'd4096;
      if (en && sav_s.size() == 4) send_err(16'($urandom), gs, gr);
      send_arg(a, fwd_sig(a), fwd_relu(a));
      check("rand_cnt", cnt_s, sav_s.size());
      if (en && sav_s.size() > 0 && $urandom_range(1, 0) == 1) send_err(16'($urandom), gs, gr);
    end
    en = 1'b1;
    while (sav_s.size() > 0) send_err(16'($urandom), gs, gr);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("sb_res_sig_left", exp_res_s.size(), 0);
    check("sb_res_relu_left", exp_res_r.size(), 0);
    check("sb_fbk_sig_left", exp_fbk_s.size(), 0);
    check("sb_fbk_relu_left", exp_fbk_r.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
